sdinit_avalon_bridge: RTL and testbench

Downstream consumer of the SD-card block loader. It accepts 16-bit word writes over the loader's `ram_we`/`ram_op_begun` handshake and buffers them in a small FIFO. It then issues them as Avalon-MM write transfers to the SDRAM/SRAM controller. It also tracks address continuity and reports when the whole image has physically landed in memory.

---
 rtl/sdinit_avalon_bridge.sv | 155 +++++++++++++++
 tb/tb_sdinit_avalon_bridge.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdinit_avalon_bridge.sv
// sdinit_avalon_bridge
// Takes 16-bit words from the SD-card block loader, buffers them in a small
// FIFO and replays them as Avalon-MM writes. It also watches that loader
// addresses stay contiguous and flags when the whole image has reached memory.
module sdinit_avalon_bridge #(
   parameter int FIFO_DEPTH = 8,
   parameter int ADDR_W     = 25
) (
   input  logic              clk50,
   input  logic              reset,
   input  logic              ram_we,
   input  logic [ADDR_W-1:0] ram_address,
   input  logic [15:0]       ram_data,
   output logic              ram_op_begun,
   input  logic              init_done,
   output logic [ADDR_W:0]   avm_address,
   output logic              avm_write,
   output logic [15:0]       avm_writedata,
   output logic [1:0]        avm_byteenable,
   input  logic              avm_waitrequest,
   output logic [ADDR_W-1:0] words_written,
   output logic              seq_error,
   output logic              load_complete
);

   localparam int PTR_W   = $clog2(FIFO_DEPTH);
   localparam int ENTRY_W = ADDR_W + 16;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_WRITE = 1'b1;

   localparam logic [PTR_W:0]    PTR_ONE  = {{PTR_W{1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   logic [ENTRY_W-1:0] fifo_mem_r [FIFO_DEPTH];
   logic [PTR_W:0]     wr_ptr_r;
   logic [PTR_W:0]     rd_ptr_r;
   logic [0:0]         state_r;
   logic [ADDR_W:0]    avm_address_r;
   logic [15:0]        avm_writedata_r;
   logic [ADDR_W-1:0]  words_written_r;
   logic [ADDR_W-1:0]  expected_addr_r;
   logic               seq_error_r;
   logic               load_complete_r;

   logic               empty_s;
   logic               full_s;
   logic               push_s;
   logic               pop_s;
   logic [ENTRY_W-1:0] head_s;

   // FIFO status from registered pointers, push/pop qualification and head read
   always_comb begin
      empty_s = (wr_ptr_r == rd_ptr_r);
      full_s  = (wr_ptr_r[PTR_W] != rd_ptr_r[PTR_W]) &&
                (wr_ptr_r[PTR_W-1:0] == rd_ptr_r[PTR_W-1:0]);
      push_s  = ram_we & ~full_s;
      head_s  = fifo_mem_r[rd_ptr_r[PTR_W-1:0]];
      if (empty_s) begin
         pop_s = 1'b0;
      end else if (state_r == ST_IDLE) begin
         pop_s = 1'b1;
      end else begin
         pop_s = ~avm_waitrequest;
      end
   end

   // FIFO storage; contents are don't-care while the pointers say empty
   always_ff @(posedge clk50) begin
      if (push_s) begin
         fifo_mem_r[wr_ptr_r[PTR_W-1:0]] <= {ram_address, ram_data};
      end
   end

   // FIFO read/write pointers
   always_ff @(posedge clk50 or posedge reset) begin
      if (reset) begin
         wr_ptr_r <= {(PTR_W+1){1'b0}};
         rd_ptr_r <= {(PTR_W+1){1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
      end
   end

   // Avalon output stage: load the head on entry or on each completed transfer
   always_ff @(posedge clk50 or posedge reset) begin
      if (reset) begin
         state_r         <= ST_IDLE;
         avm_address_r   <= {(ADDR_W+1){1'b0}};
         avm_writedata_r <= 16'h0000;
         words_written_r <= {ADDR_W{1'b0}};
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (!empty_s) begin
                  avm_address_r   <= {head_s[ENTRY_W-1:16], 1'b0};
                  avm_writedata_r <= head_s[15:0];
                  state_r         <= ST_WRITE;
               end
            end
            ST_WRITE: begin
               if (!avm_waitrequest) begin
                  words_written_r <= words_written_r + ADDR_ONE;
                  if (!empty_s) begin
                     avm_address_r   <= {head_s[ENTRY_W-1:16], 1'b0};
                     avm_writedata_r <= head_s[15:0];
                  end else begin
                     state_r <= ST_IDLE;
                  end
               end
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   // Address continuity tracking; a gap is flagged but the word is still kept
   always_ff @(posedge clk50 or posedge reset) begin
      if (reset) begin
         expected_addr_r <= {ADDR_W{1'b0}};
         seq_error_r     <= 1'b0;
      end else if (push_s) begin
         expected_addr_r <= ram_address + ADDR_ONE;
         if (ram_address != expected_addr_r) begin
            seq_error_r <= 1'b1;
         end
      end
   end

   // Image-landed flag: loader finished, nothing buffered, nothing in flight
   always_ff @(posedge clk50 or posedge reset) begin
      if (reset) begin
         load_complete_r <= 1'b0;
      end else begin
         load_complete_r <= init_done & empty_s & (state_r == ST_IDLE);
      end
   end

   assign ram_op_begun   = push_s;
   assign avm_write      = (state_r == ST_WRITE);
   assign avm_address    = avm_address_r;
   assign avm_writedata  = avm_writedata_r;
   assign avm_byteenable = 2'b11;
   assign words_written  = words_written_r;
   assign seq_error      = seq_error_r;
   assign load_complete  = load_complete_r;

endmodule

// File: tb/tb_sdinit_avalon_bridge.sv
// Testbench for sdinit_avalon_bridge: accepted pushes feed an expected-write
// queue that is popped and compared on every completed Avalon transfer.
module tb_sdinit_avalon_bridge;

   localparam int ADDR_W = 25;

   logic              clk50 = 1'b0;
   logic              reset;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_address;
   logic [15:0]       ram_data;
   logic              ram_op_begun;
   logic              init_done;
   logic [ADDR_W:0]   avm_address;
   logic              avm_write;
   logic [15:0]       avm_writedata;
   logic [1:0]        avm_byteenable;
   logic              avm_waitrequest;
   logic [ADDR_W-1:0] words_written;
   logic              seq_error;
   logic              load_complete;

   int n_checks = 0;
   int n_fail   = 0;
   int n_done   = 0;

   typedef struct packed {
      logic [ADDR_W-1:0] a;
      logic [15:0]       d;
   } ent_t;

   ent_t exp_q[$];

   always #5 clk50 = ~clk50;

   sdinit_avalon_bridge #(.FIFO_DEPTH(8), .ADDR_W(ADDR_W)) dut (
      .clk50          (clk50),
      .reset          (reset),
      .ram_we         (ram_we),
      .ram_address    (ram_address),
      .ram_data       (ram_data),
      .ram_op_begun   (ram_op_begun),
      .init_done      (init_done),
      .avm_address    (avm_address),
      .avm_write      (avm_write),
      .avm_writedata  (avm_writedata),
      .avm_byteenable (avm_byteenable),
      .avm_waitrequest(avm_waitrequest),
      .words_written  (words_written),
      .seq_error      (seq_error),
      .load_complete  (load_complete)
   );

   // Scoreboard: record accepted pushes, check each completed Avalon write
   always @(negedge clk50) begin
      ent_t e;
      if (!reset) begin
         if (ram_we && ram_op_begun) begin
            exp_q.push_back({ram_address, ram_data});
         end
         if (avm_write && !avm_waitrequest) begin
            n_checks++;
            n_done++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL sb_unexpected: write addr=%0h data=%0h, want no write", avm_address, avm_writedata);
            end else begin
               e = exp_q.pop_front();
               if (avm_address !== {e.a, 1'b0} || avm_writedata !== e.d) begin
                  n_fail++;
                  $display("FAIL sb_write: addr=%0h data=%0h, want addr=%0h data=%0h",
                           avm_address, avm_writedata, {e.a, 1'b0}, e.d);
               end
            end
         end
      end
   end

   task automatic next_cycle();
      @(posedge clk50);
      #1;
   endtask

   task automatic sample();
      @(negedge clk50);
   endtask

   task automatic do_reset();
      ram_we = 1'b0; ram_address = '0; ram_data = 16'h0000;
      init_done = 1'b0; avm_waitrequest = 1'b0;
      reset = 1'b1;
      next_cycle();
      next_cycle();
      exp_q.delete();
      n_done = 0;
      reset = 1'b0;
      next_cycle();
   endtask

   task automatic test_reset();
      ram_we = 1'b0; ram_address = '0; ram_data = 16'h0000;
      init_done = 1'b0; avm_waitrequest = 1'b0;
      reset = 1'b1;
      sample();
      n_checks++; if (avm_write !== 1'b0) begin n_fail++; $display("FAIL rst_write: got %b want 0", avm_write); end
      n_checks++; if (avm_address !== '0) begin n_fail++; $display("FAIL rst_addr: got %0h want 0", avm_address); end
      n_checks++; if (avm_writedata !== 16'h0000) begin n_fail++; $display("FAIL rst_data: got %0h want 0", avm_writedata); end
      n_checks++; if (words_written !== '0) begin n_fail++; $display("FAIL rst_words: got %0d want 0", words_written); end
      n_checks++; if (seq_error !== 1'b0) begin n_fail++; $display("FAIL rst_seq: got %b want 0", seq_error); end
      n_checks++; if (load_complete !== 1'b0) begin n_fail++; $display("FAIL rst_lc: got %b want 0", load_complete); end
      n_checks++; if (avm_byteenable !== 2'b11) begin n_fail++; $display("FAIL rst_be: got %b want 11", avm_byteenable); end
      n_checks++; if (ram_op_begun !== 1'b0) begin n_fail++; $display("FAIL rst_ack: got %b want 0", ram_op_begun); end
      next_cycle();
      reset = 1'b0;
      next_cycle();
      sample();
      n_checks++; if (avm_write !== 1'b0 || ram_op_begun !== 1'b0) begin
         n_fail++; $display("FAIL rst_idle: write=%b ack=%b want 0 0", avm_write, ram_op_begun);
      end
      next_cycle();
   endtask

   task automatic test_single_word();
      do_reset();
      ram_we = 1'b1; ram_address = '0; ram_data = 16'hA55A;
      sample();
      n_checks++; if (ram_op_begun !== 1'b1) begin n_fail++; $display("FAIL single_ack: got %b want 1", ram_op_begun); end
      next_cycle();
      ram_we = 1'b0;
      sample();
      n_checks++; if (avm_write !== 1'b0) begin n_fail++; $display("FAIL single_n1: write=%b want 0", avm_write); end
      next_cycle();
      sample();
      n_checks++; if (avm_write !== 1'b1 || avm_address !== '0 || avm_writedata !== 16'hA55A) begin
         n_fail++; $display("FAIL single_n2: write=%b addr=%0h data=%0h want 1 0 a55a", avm_write, avm_address, avm_writedata);
      end
      next_cycle();
      sample();
      n_checks++; if (avm_write !== 1'b0) begin n_fail++; $display("FAIL single_n3: write=%b want 0", avm_write); end
      n_checks++; if (words_written !== ADDR_W'(1)) begin n_fail++; $display("FAIL single_words: got %0d want 1", words_written); end
      next_cycle();
      n_checks++; if (n_done != 1 || exp_q.size() != 0) begin
         n_fail++; $display("FAIL single_sb: done=%0d pending=%0d want 1 0", n_done, exp_q.size());
      end
   endtask

   task automatic test_stall();
      logic want;
      logic ok;
      do_reset();
      avm_waitrequest = 1'b1;
      for (int i = 0; i < 10; i++) begin
         ram_we = 1'b1; ram_address = ADDR_W'(i); ram_data = 16'h1000 + 16'(i);
         sample();
         want = (i < 9) ? 1'b1 : 1'b0;
         n_checks++; if (ram_op_begun !== want) begin
            n_fail++; $display("FAIL stall_ack[%0d]: got %b want %b", i, ram_op_begun, want);
         end
         if (i < 9) next_cycle();
      end
      next_cycle();
      sample();
      n_checks++; if (ram_op_begun !== 1'b0) begin n_fail++; $display("FAIL stall_hold: got %b want 0", ram_op_begun); end
      next_cycle();
      avm_waitrequest = 1'b0;
      sample();
      n_checks++; if (ram_op_begun !== 1'b0 || avm_write !== 1'b1) begin
         n_fail++; $display("FAIL full_pop_edge: ack=%b write=%b want 0 1", ram_op_begun, avm_write);
      end
      next_cycle();
      sample();
      n_checks++; if (ram_op_begun !== 1'b1) begin n_fail++; $display("FAIL full_after_pop: ack=%b want 1", ram_op_begun); end
      next_cycle();
      ram_we = 1'b0;
      ok = 1'b1;
      for (int c = 0; c < 8; c++) begin
         sample();
         if (avm_write !== 1'b1) ok = 1'b0;
         next_cycle();
      end
      n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL stall_b2b: gap=%b want no gap", ~ok); end
      sample();
      n_checks++; if (avm_write !== 1'b0) begin n_fail++; $display("FAIL stall_end: write=%b want 0", avm_write); end
      next_cycle();
      sample();
      n_checks++; if (words_written !== ADDR_W'(10)) begin n_fail++; $display("FAIL stall_words: got %0d want 10", words_written); end
      next_cycle();
      n_checks++; if (n_done != 10 || exp_q.size() != 0) begin
         n_fail++; $display("FAIL stall_sb: done=%0d pending=%0d want 10 0", n_done, exp_q.size());
      end
   endtask

   task automatic test_streaming();
      int missed;
      int t;
      missed = 0;
      do_reset();
      init_done = 1'b1;
      for (int i = 0; i < 512; i++) begin
         for (int c = 0; c < 4; c++) begin
            avm_waitrequest = ($urandom_range(99) < 30);
            if (c == 0) begin
               ram_we = 1'b1; ram_address = ADDR_W'(i); ram_data = 16'($urandom);
               sample();
               if (ram_op_begun !== 1'b1) missed++;
            end else begin
               ram_we = 1'b0;
            end
            next_cycle();
         end
      end
      ram_we = 1'b0;
      avm_waitrequest = 1'b0;
      t = 0;
      while ((exp_q.size() != 0 || avm_write) && t < 200) begin
         next_cycle();
         t++;
      end
      n_checks++; if (t >= 200) begin n_fail++; $display("FAIL stream_drain: pending=%0d want 0 within 200 cycles", exp_q.size()); end
      next_cycle();
      next_cycle();
      sample();
      n_checks++; if (missed != 0) begin n_fail++; $display("FAIL stream_ack: missed=%0d want 0", missed); end
      n_checks++; if (words_written !== ADDR_W'(512)) begin n_fail++; $display("FAIL stream_words: got %0d want 512", words_written); end
      n_checks++; if (seq_error !== 1'b0) begin n_fail++; $display("FAIL stream_seq: got %b want 0", seq_error); end
      n_checks++; if (load_complete !== 1'b1) begin n_fail++; $display("FAIL stream_lc: got %b want 1", load_complete); end
      next_cycle();
      n_checks++; if (n_done != 512) begin n_fail++; $display("FAIL stream_done: got %0d want 512", n_done); end
   endtask

   task automatic test_discontinuity();
      int addrs[4] = '{0, 1, 3, 4};
      do_reset();
      for (int k = 0; k < 4; k++) begin
         ram_we = 1'b1; ram_address = ADDR_W'(addrs[k]); ram_data = 16'hD000 + 16'(k);
         sample();
         if (k == 2) begin
            n_checks++; if (seq_error !== 1'b0) begin n_fail++; $display("FAIL disc_before: got %b want 0", seq_error); end
         end
         if (k == 3) begin
            n_checks++; if (seq_error !== 1'b1) begin n_fail++; $display("FAIL disc_rise: got %b want 1", seq_error); end
         end
         next_cycle();
      end
      ram_we = 1'b0;
      repeat (6) next_cycle();
      sample();
      n_checks++; if (seq_error !== 1'b1) begin n_fail++; $display("FAIL disc_sticky: got %b want 1", seq_error); end
      next_cycle();
      n_checks++; if (n_done != 4 || exp_q.size() != 0) begin
         n_fail++; $display("FAIL disc_sb: done=%0d pending=%0d want 4 0", n_done, exp_q.size());
      end
   endtask

   task automatic test_reset_mid();
      logic ok;
      do_reset();
      avm_waitrequest = 1'b1;
      for (int k = 0; k < 4; k++) begin
         ram_we = 1'b1; ram_address = ADDR_W'(k); ram_data = 16'hE000 + 16'(k);
         next_cycle();
      end
      ram_we = 1'b0;
      sample();
      n_checks++; if (avm_write !== 1'b1) begin n_fail++; $display("FAIL mid_pre: write=%b want 1", avm_write); end
      #1 reset = 1'b1;
      #1;
      n_checks++; if (avm_write !== 1'b0) begin n_fail++; $display("FAIL mid_async: write=%b want 0", avm_write); end
      n_checks++; if (words_written !== '0 || avm_address !== '0) begin
         n_fail++; $display("FAIL mid_clear: words=%0d addr=%0h want 0 0", words_written, avm_address);
      end
      exp_q.delete();
      n_done = 0;
      next_cycle();
      next_cycle();
      reset = 1'b0;
      avm_waitrequest = 1'b0;
      ok = 1'b1;
      for (int c = 0; c < 3; c++) begin
         sample();
         if (avm_write !== 1'b0) ok = 1'b0;
         next_cycle();
      end
      n_checks++; if (ok !== 1'b1 || n_done != 0) begin
         n_fail++; $display("FAIL mid_flushed: stale_write=%b done=%0d want 0 0", ~ok, n_done);
      end
      ram_we = 1'b1; ram_address = '0; ram_data = 16'h5AA5;
      sample();
      n_checks++; if (ram_op_begun !== 1'b1) begin n_fail++; $display("FAIL mid_new_ack: got %b want 1", ram_op_begun); end
      next_cycle();
      ram_we = 1'b0;
      next_cycle();
      sample();
      n_checks++; if (avm_write !== 1'b1 || avm_address !== '0 || avm_writedata !== 16'h5AA5) begin
         n_fail++; $display("FAIL mid_new_write: write=%b addr=%0h data=%0h want 1 0 5aa5", avm_write, avm_address, avm_writedata);
      end
      next_cycle();
      next_cycle();
      sample();
      n_checks++; if (words_written !== ADDR_W'(1) || seq_error !== 1'b0) begin
         n_fail++; $display("FAIL mid_new_count: words=%0d seq=%b want 1 0", words_written, seq_error);
      end
      next_cycle();
      n_checks++; if (n_done != 1) begin n_fail++; $display("FAIL mid_new_sb: done=%0d want 1", n_done); end
   endtask

   task automatic test_completion();
      logic ok;
      do_reset();
      avm_waitrequest = 1'b1;
      for (int k = 0; k < 3; k++) begin
         ram_we = 1'b1; ram_address = ADDR_W'(k); ram_data = 16'hF000 + 16'(k);
         next_cycle();
      end
      ram_we = 1'b0;
      init_done = 1'b1;
      ok = 1'b1;
      repeat (3) begin
         sample();
         if (load_complete !== 1'b0) ok = 1'b0;
         next_cycle();
      end
      n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL gate_hold: lc rose=%b want 0", ~ok); end
      avm_waitrequest = 1'b0;
      ok = 1'b1;
      for (int c = 0; c < 4; c++) begin
         sample();
         if (load_complete !== 1'b0) ok = 1'b0;
         next_cycle();
      end
      n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL gate_drain: lc early=%b want 0", ~ok); end
      sample();
      n_checks++; if (load_complete !== 1'b1) begin n_fail++; $display("FAIL gate_rise: got %b want 1", load_complete); end
      next_cycle();
      init_done = 1'b0;
      sample();
      n_checks++; if (load_complete !== 1'b1) begin n_fail++; $display("FAIL gate_reg: got %b want 1", load_complete); end
      next_cycle();
      sample();
      n_checks++; if (load_complete !== 1'b0) begin n_fail++; $display("FAIL gate_drop: got %b want 0", load_complete); end
      next_cycle();
      n_checks++; if (n_done != 3 || exp_q.size() != 0) begin
         n_fail++; $display("FAIL gate_sb: done=%0d pending=%0d want 3 0", n_done, exp_q.size());
      end
   endtask

   // Bound on total run time
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
      $fatal(1, "watchdog expired");
   end

   // Test sequence
   initial begin
      test_reset();
      test_single_word();
      test_stall();
      test_streaming();
      test_discontinuity();
      test_reset_mid();
      test_completion();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
